// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the sequential RV32I ALU.
//   alu_op_e    - 4-bit operation codes; the low four keep the legacy 2-bit values
//   alu_state_e - control FSM states of alu_seq
//   is_shift()  - true for the iterative shift operations
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SLT  = 4'b0101,
        OP_SLTU = 4'b0110,
        OP_SLL  = 4'b0111,
        OP_SRL  = 4'b1000,
        OP_SRA  = 4'b1001
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } alu_state_e;

    function automatic logic is_shift(input alu_op_e op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_core_comb.sv
// alu_core_comb: purely combinational single-cycle ALU operations.
//   a, b : WIDTH-bit operands
//   op   : 4-bit operation code (alu_op_e encoding)
//   y    : result; shift codes and unused codes yield 0 here
module alu_core_comb
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (alu_op_e'(op))
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SLT:  y[0] = ($signed(a) < $signed(b));
            OP_SLTU: y[0] = (a < b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked RV32I ALU with registered result and iterative shifter.
//   clk, reset_n          : clock, synchronous active-low reset
//   in_valid / in_ready   : operation handshake (SrcA, SrcB, ALUControl)
//   out_valid / out_ready : result handshake (ALUResult, Zero)
// Shifts advance SHIFT_STEP bits per cycle; everything else completes in one.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [3:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero
);

    localparam int unsigned SW = $clog2(WIDTH);
    localparam int unsigned CW = SW + 1;
    localparam logic [CW-1:0] STEP = CW'(SHIFT_STEP);

    alu_state_e      state, state_next;
    alu_op_e         op_in, op_q;
    logic [WIDTH-1:0] wrk, wrk_shifted;
    logic [CW-1:0]   cnt, cnt_next, step;
    logic [SW-1:0]   amt;
    logic            accept, start_shift;
    logic [WIDTH-1:0] core_y, imm_result;

    assign op_in = alu_op_e'(ALUControl);
    assign amt   = SrcB[SW-1:0];

    alu_core_comb #(.WIDTH(WIDTH)) u_core (
        .a  (SrcA),
        .b  (SrcB),
        .op (ALUControl),
        .y  (core_y)
    );

    // A zero-amount shift is just SrcA and finishes like any single-cycle op.
    assign start_shift = is_shift(op_in) && (amt != '0);
    assign imm_result  = is_shift(op_in) ? SrcA : core_y;

    // Last iteration may be shorter than SHIFT_STEP.
    always_comb begin
        step     = (cnt > STEP) ? STEP : cnt;
        cnt_next = cnt - step;
        case (op_q)
            OP_SLL:  wrk_shifted = wrk << step;
            OP_SRL:  wrk_shifted = wrk >> step;
            default: wrk_shifted = $unsigned($signed(wrk) >>> step);
        endcase
    end

    always_comb begin
        in_ready   = (state == IDLE) || ((state == DONE) && out_ready);
        accept     = in_valid && in_ready;
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = start_shift ? SHIFT : DONE;
            end
            SHIFT: begin
                if (cnt_next == '0) state_next = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    if (accept) state_next = start_shift ? SHIFT : DONE;
                    else        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_q      <= OP_ADD;
            wrk       <= '0;
            cnt       <= '0;
            ALUResult <= '0;
            Zero      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= (state_next == DONE);
            if (accept) begin
                op_q <= op_in;
                if (start_shift) begin
                    wrk <= SrcA;
                    cnt <= {1'b0, amt};
                end else begin
                    ALUResult <= imm_result;
                    Zero      <= (imm_result == '0);
                end
            end else if (state == SHIFT) begin
                wrk <= wrk_shifted;
                cnt <= cnt_next;
                if (cnt_next == '0) begin
                    ALUResult <= wrk_shifted;
                    Zero      <= (wrk_shifted == '0);
                end
            end
        end
    end

endmodule
